icache_ctrl_nway: RTL and testbench

ICACHE_CTRL_NWAY -- requirements
Module: icache_ctrl_nway

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_plru.sv | 51 +++++
 rtl/icache_ctrl_nway.sv | 186 ++++++++++++++++++
 tb/tb_icache_ctrl_nway.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state encoding and width helper for the n-way icache
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_MISS   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  // ceil(log2(v)) for elaboration-time width derivation
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// rtl/icache_plru.sv - tree-PLRU victim selection and access update for one set
module icache_plru
  import icache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int PW   = (WAYS > 1) ? WAYS - 1 : 1,
  parameter int WW   = (WAYS > 1) ? clog2(WAYS) : 1
) (
  input  logic [PW-1:0]   bits_i,
  input  logic [WAYS-1:0] valid_i,
  input  logic [WW-1:0]   acc_way_i,
  output logic [WW-1:0]   victim_o,
  output logic [PW-1:0]   bits_o
);

  localparam int LV = clog2(WAYS);

  // Victim: lowest invalid way wins, otherwise walk the tree (bit=1 means victim on the right)
  always_comb begin
    int  node;
    logic found;
    victim_o = '0;
    node     = 1;
    for (int l = 0; l < LV; l++) begin
      node = node * 2 + int'(bits_i[node-1]);
    end
    if (WAYS > 1) victim_o = WW'(node - WAYS);
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        victim_o = WW'(w);
        found    = 1'b1;
      end
    end
  end

  // Update: every node on the accessed way's path is pointed at the opposite subtree
  always_comb begin
    int leaf;
    int node;
    int dir;
    bits_o = bits_i;
    leaf   = int'(acc_way_i) + WAYS;
    for (int l = 0; l < LV; l++) begin
      node = leaf >> (LV - l);
      dir  = (leaf >> (LV - l - 1)) & 1;
      bits_o[node-1] = (dir == 0);
    end
  end

endmodule

// File: rtl/icache_ctrl_nway.sv
// rtl/icache_ctrl_nway.sv - n-way set-associative instruction cache controller
module icache_ctrl_nway
  import icache_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int WAYS   = 2,
  parameter int SETS   = 256,
  parameter int WORDS  = 4,
  parameter int OFF_W  = clog2(WORDS),
  parameter int IDX_W  = clog2(SETS),
  parameter int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_req,
  input  logic [ADDR_W-1:0]           if_addr,
  input  logic                        flush,
  output logic [31:0]                 cpu_data,
  output logic                        data_rdy,
  output logic                        miss_stall,
  output logic                        flush_done,
  output logic [IDX_W-1:0]            index,
  input  logic [WAYS*(TAG_W+1)-1:0]   tag_rd,
  input  logic [WAYS*WORDS*32-1:0]    data_rd,
  output logic [WAYS-1:0]             way_we,
  output logic [TAG_W:0]              tag_wd,
  output logic                        l2_req,
  output logic [ADDR_W-OFF_W-1:0]     l2_addr,
  input  logic                        l2_gnt,
  input  logic                        l2_rdy,
  input  logic [WORDS*32-1:0]         l2_data
);

  localparam int TE_W = TAG_W + 1;
  localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int WW   = (WAYS > 1) ? clog2(WAYS) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              fpend_q, fpend_d;
  logic [PW-1:0]     plru_q [SETS];

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [OFF_W-1:0]  a_off;
  logic [WAYS-1:0]   vld;
  logic              hit;
  logic [WW-1:0]     hit_way, victim, acc_way;
  logic [PW-1:0]     plru_upd;
  logic              plru_we, refill_done;
  logic [31:0]       hit_word, l2_word;

  assign a_tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign a_idx       = addr_q[OFF_W +: IDX_W];
  assign a_off       = addr_q[OFF_W-1:0];
  assign hit_word    = data_rd[(int'(hit_way) * WORDS + int'(a_off)) * 32 +: 32];
  assign l2_word     = l2_data[int'(a_off) * 32 +: 32];
  assign acc_way     = (state_q == ST_MISS) ? victim : hit_way;
  // A refill coinciding with reset is dropped so the array is never written with it
  assign refill_done = (state_q == ST_MISS) && l2_gnt && l2_rdy && !rst;

  // Tag compare across ways; lowest matching way wins
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vld     = '0;
    for (int w = 0; w < WAYS; w++) begin
      vld[w] = tag_rd[w*TE_W + TAG_W];
      if (!hit && vld[w] && (tag_rd[w*TE_W +: TAG_W] == a_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  icache_plru #(.WAYS(WAYS)) u_plru (
    .bits_i    (plru_q[a_idx]),
    .valid_i   (vld),
    .acc_way_i (acc_way),
    .victim_o  (victim),
    .bits_o    (plru_upd)
  );

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    fpend_d    = fpend_q;
    plru_we    = 1'b0;
    cpu_data   = '0;
    data_rdy   = 1'b0;
    miss_stall = 1'b0;
    flush_done = 1'b0;
    index      = if_addr[OFF_W +: IDX_W];
    way_we     = '0;
    tag_wd     = '0;
    l2_req     = 1'b0;
    l2_addr    = '0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (if_req) begin
          addr_d  = if_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          data_rdy = 1'b1;
          cpu_data = hit_word;
          plru_we  = 1'b1;
          if (flush) begin
            state_d = ST_FLUSH;
          end else if (if_req) begin
            addr_d = if_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          // Hold the missing set on the arrays so the victim sees its valid bits
          index      = a_idx;
          miss_stall = 1'b1;
          l2_addr    = addr_q[ADDR_W-1:OFF_W];
          state_d    = flush ? ST_FLUSH : ST_MISS;
        end
      end
      ST_MISS: begin
        index   = a_idx;
        l2_req  = 1'b1;
        l2_addr = addr_q[ADDR_W-1:OFF_W];
        if (flush) fpend_d = 1'b1;
        if (refill_done) begin
          way_we   = WAYS'(1) << victim;
          tag_wd   = {1'b1, a_tag};
          data_rdy = 1'b1;
          cpu_data = l2_word;
          plru_we  = 1'b1;
          fpend_d  = 1'b0;
          state_d  = (fpend_q || flush) ? ST_FLUSH : ST_IDLE;
        end else begin
          miss_stall = 1'b1;
        end
      end
      ST_FLUSH: begin
        index      = cnt_q;
        way_we     = '1;
        miss_stall = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) begin
          flush_done = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // Control state register; reset starts an invalidate sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FLUSH;
      addr_q  <= '0;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      fpend_q <= fpend_d;
    end
  end

  // Per-set PLRU bits, cleared on reset and at the end of a flush
  always_ff @(posedge clk) begin
    if (rst || flush_done) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (plru_we) begin
      plru_q[a_idx] <= plru_upd;
    end
  end

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// tb/tb_icache_ctrl_nway.sv - self-checking bench for icache_ctrl_nway with array/L2 models
module tb_icache_ctrl_nway;

  logic         clk = 1'b0;
  logic         rst, if_req, flush, l2_gnt, l2_rdy;
  logic [29:0]  if_addr;
  logic [31:0]  cpu_data;
  logic         data_rdy, miss_stall, flush_done, l2_req;
  logic [7:0]   index;
  logic [41:0]  tag_rd;
  logic [255:0] data_rd;
  logic [1:0]   way_we;
  logic [20:0]  tag_wd;
  logic [27:0]  l2_addr;
  logic [127:0] l2_data;

  int tests = 0;
  int fails = 0;
  logic [1:0] last_we;

  // reference cache contents: valid, tag and most-recently-used way per set
  bit rv [2][256];
  int rt [2][256];
  int rm [256];

  always #5 clk = ~clk;

  icache_ctrl_nway dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .cpu_data(cpu_data), .data_rdy(data_rdy), .miss_stall(miss_stall),
    .flush_done(flush_done), .index(index), .tag_rd(tag_rd), .data_rd(data_rd),
    .way_we(way_we), .tag_wd(tag_wd), .l2_req(l2_req), .l2_addr(l2_addr),
    .l2_gnt(l2_gnt), .l2_rdy(l2_rdy), .l2_data(l2_data)
  );

  function automatic logic [31:0] exp_word(input logic [29:0] a);
    if (a == 30'h100) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  // L2 backing store: line contents are a pure function of the word address
  always_comb begin
    for (int k = 0; k < 4; k++) l2_data[k*32 +: 32] = exp_word({l2_addr, 2'(k)});
  end

  // tag/data arrays: synchronous read, write on way_we; start full of garbage
  logic [20:0]  tmem [2][256];
  logic [127:0] dmem [2][256];
  bit mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 256; s++) begin
          tmem[w][s] <= 21'($urandom);
          dmem[w][s] <= {$urandom, $urandom, $urandom, $urandom};
        end
      mem_init <= 1'b1;
    end else begin
      tag_rd  <= {tmem[1][index], tmem[0][index]};
      data_rd <= {dmem[1][index], dmem[0][index]};
      for (int w = 0; w < 2; w++)
        if (way_we[w] === 1'b1) begin
          tmem[w][index] <= tag_wd;
          dmem[w][index] <= l2_data;
        end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_flush();
    for (int s = 0; s < 256; s++) begin
      rv[0][s] = 0; rv[1][s] = 0; rm[s] = 1;
    end
  endtask

  // Called in the first FLUSH cycle; returns in the following IDLE cycle
  task automatic wait_flush();
    int c;
    for (c = 1; c <= 400; c++) begin
      #1;
      chk("flush_we", way_we, 2'b11);
      chk("flush_rdy", data_rdy, 1'b0);
      if (flush_done === 1'b1) break;
      step();
    end
    chk("flush_len", c, 256);
    step();
    model_flush();
  endtask

  task automatic fetch(input logic [29:0] a, input int gdelay, input bit rnd_rdy, input bit fl_mid);
    int s, tg, ew, ev, cyc;
    bit ehit, done;
    s  = int'((a >> 2) & 30'hFF);
    tg = int'(a >> 10);
    ehit = 0; ew = 0;
    for (int w = 0; w < 2; w++)
      if (!ehit && rv[w][s] && rt[w][s] == tg) begin ehit = 1; ew = w; end
    if_req  = 1'b1;
    if_addr = a;
    step();
    if_req = 1'b0;
    #1;
    chk("hit", data_rdy, ehit);
    if (ehit) begin
      chk("hit_data", cpu_data, exp_word(a));
      chk("hit_noreq", l2_req, 1'b0);
      chk("hit_nostall", miss_stall, 1'b0);
      rm[s] = ew;
      step();
    end else begin
      chk("miss_stall", miss_stall, 1'b1);
      if (!rv[0][s]) ev = 0;
      else if (!rv[1][s]) ev = 1;
      else ev = 1 - rm[s];
      step();
      cyc = 0; done = 0;
      while (!done && cyc < 100) begin
        l2_gnt = (cyc >= gdelay);
        l2_rdy = (rnd_rdy && cyc >= gdelay) ? 1'($urandom_range(0, 1)) : 1'b1;
        flush  = fl_mid && (cyc == 0);
        #1;
        chk("l2_addr", l2_addr, a >> 2);
        if (l2_gnt && l2_rdy) begin
          chk("fill_rdy", data_rdy, 1'b1);
          chk("fill_data", cpu_data, exp_word(a));
          chk("fill_we", way_we, 2'b01 << ev);
          chk("fill_tag", tag_wd, {1'b1, 20'(tg)});
          chk("fill_nostall", miss_stall, 1'b0);
          last_we = way_we;
          done = 1;
        end else begin
          chk("wait_req", l2_req, 1'b1);
          chk("wait_we", way_we, 2'b00);
          chk("wait_stall", miss_stall, 1'b1);
          chk("wait_rdy", data_rdy, 1'b0);
        end
        step();
        flush = 1'b0;
        cyc++;
      end
      l2_gnt = 1'b0; l2_rdy = 1'b0;
      chk("refill_timeout", done, 1'b1);
      rv[ev][s] = 1; rt[ev][s] = tg; rm[s] = ev;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0; l2_gnt = 1'b0; l2_rdy = 1'b0;
    last_we = '0;
    model_flush();
    step(); step(); step();
    rst = 1'b0;
    #1;
    chk("rst_stall", miss_stall, 1'b1);
    chk("rst_we", way_we, 2'b11);
    chk("rst_rdy", data_rdy, 1'b0);
    chk("rst_req", l2_req, 1'b0);
    chk("rst_done", flush_done, 1'b0);
    chk("rst_cpu", cpu_data, 32'h0);
    chk("rst_tag", tag_wd, 21'h0);
    wait_flush();

    fetch(30'h100, 0, 0, 0);
    chk("cold_way0", last_we, 2'b01);
    fetch(30'h101, 0, 0, 0);

    // back-to-back hits: request held high during LOOKUP
    if_req = 1'b1; if_addr = 30'h100;
    step();
    if_addr = 30'h102;
    #1;
    chk("b2b_rdy0", data_rdy, 1'b1);
    chk("b2b_data0", cpu_data, exp_word(30'h100));
    step();
    if_req = 1'b0;
    #1;
    chk("b2b_rdy1", data_rdy, 1'b1);
    chk("b2b_data1", cpu_data, exp_word(30'h102));
    rm[8'h40] = 0;
    step();

    fetch(30'h500, 0, 0, 0);
    fetch(30'h100, 0, 0, 0);
    fetch(30'h900, 0, 0, 0);
    chk("repl_way1", last_we, 2'b10);
    fetch(30'h103, 0, 0, 0);
    fetch(30'h501, 0, 0, 0);

    fetch(30'h1234, 5, 0, 0);

    // flush requested mid-refill is deferred until the refill finishes
    fetch(30'h2222, 2, 0, 1);
    wait_flush();
    fetch(30'h100, 0, 0, 0);

    // reset during a refill with coincident ready
    if_req = 1'b1; if_addr = 30'h2000;
    step();
    if_req = 1'b0;
    step();
    l2_gnt = 1'b1; l2_rdy = 1'b1; rst = 1'b1;
    #1;
    chk("rstmiss_we", way_we, 2'b00);
    chk("rstmiss_rdy", data_rdy, 1'b0);
    step();
    rst = 1'b0; l2_gnt = 1'b0; l2_rdy = 1'b0;
    #1;
    chk("rstmiss_req", l2_req, 1'b0);
    chk("rstmiss_stall", miss_stall, 1'b1);
    wait_flush();

    for (int i = 0; i < 40; i++) begin
      logic [29:0] a;
      a = (30'($urandom_range(0, 2)) << 10) | (30'($urandom_range(8'h40, 8'h41)) << 2)
          | 30'($urandom_range(0, 3));
      fetch(a, int'($urandom_range(0, 3)), 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
